// File: rtl/dz_pkg.sv
`default_nettype none
// ============================================================================
// dz_pkg : shared types and sizes for the dot-matrix digit scan controller
// Rev 1.0
// ============================================================================
package dz_pkg;

  localparam int DZ_ROWS  = 8;
  localparam int DZ_NUM_W = 3;
  localparam int DZ_ROW_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } dz_state_e;

endpackage
`default_nettype wire

// File: rtl/dz_tick_div.sv
`default_nettype none
// ============================================================================
// dz_tick_div : modulo-DIV cycle counter, one-cycle tick while at DIV-1
// Rev 1.0
// ============================================================================
module dz_tick_div #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int                 c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == c_LAST);

  // Clear outranks enable so a restart always begins a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == c_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dz_scan_ctrl.sv
`default_nettype none
// ============================================================================
// dz_scan_ctrl : countdown digit sequencer and row scanner for 8x8 matrix
// Rev 1.0
// ============================================================================
module dz_scan_ctrl
  import dz_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int SEC_DIV   = 1000000,
  parameter int START_NUM = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                pause,
  input  logic                clr,
  output logic [DZ_NUM_W-1:0] num,
  output logic [DZ_ROW_W-1:0] row_idx,
  output logic [DZ_ROWS-1:0]  row,
  output logic                busy,
  output logic                done
);

  localparam logic [DZ_NUM_W-1:0] c_START = DZ_NUM_W'(START_NUM);
  localparam logic [DZ_ROWS-1:0]  c_ROW0  = {{(DZ_ROWS-1){1'b1}}, 1'b0};

  dz_state_e           r_state;
  logic [DZ_NUM_W-1:0] r_num;
  logic [DZ_ROW_W-1:0] r_row_idx;
  logic [DZ_ROWS-1:0]  r_row;
  logic                r_busy;
  logic                r_done;

  logic                w_scan_tick;
  logic                w_step_tick;
  logic                w_sec_en;
  logic                w_sec_clr;
  logic [DZ_ROW_W-1:0] w_row_idx_nxt;

  assign w_row_idx_nxt = r_row_idx + 1'b1;
  assign w_sec_en      = (r_state == RUN);
  // Step timebase restarts on abort and on every fresh countdown launch.
  assign w_sec_clr     = clr || (start && ((r_state == IDLE) || (r_state == DONE)));

  dz_tick_div #(
    .DIV (SCAN_DIV)
  ) u_scan_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (1'b1),
    .i_clr  (1'b0),
    .o_tick (w_scan_tick)
  );

  dz_tick_div #(
    .DIV (SEC_DIV)
  ) u_step_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_sec_en),
    .i_clr  (w_sec_clr),
    .o_tick (w_step_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_num     <= c_START;
      r_row_idx <= '0;
      r_row     <= c_ROW0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_scan_tick) begin
        r_row_idx <= w_row_idx_nxt;
        r_row     <= ~(DZ_ROWS'(1) << w_row_idx_nxt);
      end

      if (clr) begin
        r_state <= IDLE;
        r_num   <= c_START;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          IDLE, DONE: begin
            if (start) begin
              if (START_NUM == 0) begin
                r_state <= DONE;
                r_num   <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= RUN;
                r_num   <= c_START;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
              end
            end
          end
          RUN: begin
            if (w_step_tick) begin
              r_num <= r_num - 1'b1;
              // Reaching zero beats a coincident pause request.
              if (r_num == DZ_NUM_W'(1)) begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else if (pause) begin
                r_state <= PAUSE;
              end
            end else if (pause) begin
              r_state <= PAUSE;
            end
          end
          PAUSE: begin
            if (pause) begin
              r_state <= RUN;
            end
          end
          default: begin
            r_state <= IDLE;
            r_num   <= c_START;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign num     = r_num;
  assign row_idx = r_row_idx;
  assign row     = r_row;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
`default_nettype wire
